// File: rtl/mem_copy_dma.sv
// Word-by-word memory copier that owns the single-port data memory while busy.
// Latency: N words -> done in cycle 2N+1 after the start edge; 1 cycle for len=0 or bounds error.
// Backpressure: none; start is ignored while busy, and abort ends the transfer at the next word boundary.
module mem_copy_dma #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_MW,
    output logic              mem_MD,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  index;
    logic [LEN_W-1:0]  count_q;
    logic              err_q;

    // One extra bit so an address near the top of the space cannot wrap past the check.
    logic [ADDR_W:0] src_end;
    logic [ADDR_W:0] dst_end;
    logic            out_of_bounds;
    logic            last_word;

    assign src_end       = {1'b0, src_addr} + (ADDR_W+1)'(len);
    assign dst_end       = {1'b0, dst_addr} + (ADDR_W+1)'(len);
    assign out_of_bounds = (src_end > DEPTH) || (dst_end > DEPTH);
    assign last_word     = ({1'b0, index} + (LEN_W+1)'(1)) == {1'b0, len_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            index   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        len_q   <= len;
                        index   <= '0;
                        count_q <= '0;
                        err_q   <= out_of_bounds;
                        if (out_of_bounds || len == '0)
                            state <= DONE;
                        else
                            state <= RD;
                    end
                end
                RD: begin
                    state <= abort ? DONE : WR;
                end
                WR: begin
                    count_q <= count_q + LEN_W'(1);
                    if (last_word || abort) begin
                        state <= DONE;
                    end else begin
                        index <= index + LEN_W'(1);
                        state <= RD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign err   = err_q;
    assign count = count_q;

    // Memory strobes follow the state directly so a reset releases the bus at once.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_MW      = 1'b0;
        mem_MD      = 1'b0;
        case (state)
            RD: begin
                mem_MD      = 1'b1;
                mem_address = src_q + ADDR_W'(index);
            end
            WR: begin
                mem_MW      = 1'b1;
                mem_address = dst_q + ADDR_W'(index);
                mem_data    = mem_out;
            end
            default: ;
        endcase
    end

endmodule
